// File: rtl/spi_display_arbiter_if.sv
// rtl/spi_display_arbiter_if.sv - client/panel signal bundle for the SPI display arbiter
// Purpose: groups the per-client request/bus signals and the shared panel bus.
// Ports (slave = arbiter side):
//   req, done, cli_mosi, cli_dc, cli_cs : per-client inputs (NUM_REQ wide)
//   start, abort, gnt                   : per-client one-hot outputs
//   mosi, dc, cs                        : muxed panel bus (cs active-low)
//   busy, timeout, init_done            : status
interface spi_display_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] cli_mosi;
    logic [NUM_REQ-1:0] cli_dc;
    logic [NUM_REQ-1:0] cli_cs;
    logic [NUM_REQ-1:0] start;
    logic [NUM_REQ-1:0] abort;
    logic [NUM_REQ-1:0] gnt;
    logic               mosi;
    logic               dc;
    logic               cs;
    logic               busy;
    logic               timeout;
    logic               init_done;

    modport master (
        output req, done, cli_mosi, cli_dc, cli_cs,
        input  start, abort, gnt, mosi, dc, cs, busy, timeout, init_done
    );

    modport slave (
        input  req, done, cli_mosi, cli_dc, cli_cs,
        output start, abort, gnt, mosi, dc, cs, busy, timeout, init_done
    );
endinterface

// File: rtl/spi_display_arbiter.sv
// rtl/spi_display_arbiter.sv - round-robin owner arbiter for a shared SPI display bus
// Purpose: grants the panel bus to one of NUM_REQ clients at a time, with an
//   init-client lock, a per-grant watchdog and an idle gap between grants.
// Ports:
//   i_clk : system clock
//   i_rst : asynchronous reset, active-high
//   bus   : spi_display_arbiter_if.slave (client requests/bus in, grant/panel out)
module spi_display_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int TIMEOUT    = 16_000_000,
    parameter int GAP_CYCLES = 4,
    parameter int INIT_LOCK  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spi_display_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   g_idx, g_idx_n;
    logic [IW-1:0]   last, last_n;
    logic [TW-1:0]   timer, timer_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic            init_done, init_done_n;

    logic [NUM_REQ-1:0] elig;
    logic [IW-1:0]      win;
    logic [NUM_REQ-1:0] g_oh;
    logic               done_g;
    logic               timer_hit;

    // Until the panel is initialised only requester 0 may be served.
    assign elig = (INIT_LOCK != 0 && !init_done)
                ? (bus.req & {{(NUM_REQ-1){1'b0}}, 1'b1})
                : bus.req;

    assign g_oh      = {{(NUM_REQ-1){1'b0}}, 1'b1} << g_idx;
    assign done_g    = bus.done[g_idx];
    assign timer_hit = (timer == TW'(TIMEOUT - 1));

    // Round-robin: first eligible client after the last one served, wrapping.
    always_comb begin
        logic found;
        logic [IW-1:0] cand;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last) + i) % NUM_REQ);
            if (!found && elig[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            g_idx     <= '0;
            last      <= IW'(NUM_REQ - 1);
            timer     <= '0;
            gap_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            g_idx     <= g_idx_n;
            last      <= last_n;
            timer     <= timer_n;
            gap_cnt   <= gap_cnt_n;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        g_idx_n     = g_idx;
        last_n      = last;
        timer_n     = timer;
        gap_cnt_n   = gap_cnt;
        init_done_n = init_done;
        case (state)
            IDLE: begin
                if (|elig) begin
                    g_idx_n = win;
                    state_n = START;
                end
            end
            START: begin
                timer_n = '0;
                state_n = BUSY;
            end
            BUSY: begin
                timer_n = timer + TW'(1);
                // Done takes priority over a watchdog expiry in the same cycle.
                if (done_g) begin
                    last_n    = g_idx;
                    gap_cnt_n = '0;
                    state_n   = GAP;
                    if (g_idx == '0) begin
                        init_done_n = 1'b1;
                    end
                end else if (timer_hit) begin
                    last_n    = g_idx;
                    gap_cnt_n = '0;
                    state_n   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus mux is purely combinational so client SPI timing passes straight through.
    always_comb begin
        bus.start   = '0;
        bus.abort   = '0;
        bus.gnt     = '0;
        bus.mosi    = 1'b0;
        bus.dc      = 1'b0;
        bus.cs      = 1'b1;
        bus.busy    = (state != IDLE);
        bus.timeout = 1'b0;
        case (state)
            START: begin
                bus.start = g_oh;
                bus.gnt   = g_oh;
                bus.mosi  = bus.cli_mosi[g_idx];
                bus.dc    = bus.cli_dc[g_idx];
                bus.cs    = bus.cli_cs[g_idx];
            end
            BUSY: begin
                bus.gnt  = g_oh;
                bus.mosi = bus.cli_mosi[g_idx];
                bus.dc   = bus.cli_dc[g_idx];
                bus.cs   = bus.cli_cs[g_idx];
                if (!done_g && timer_hit) begin
                    bus.timeout = 1'b1;
                    bus.abort   = g_oh;
                end
            end
            default: ;
        endcase
    end

    assign bus.init_done = init_done;
endmodule

// File: doc/spi_display_arbiter.md
Name: spi_display_arbiter

Overview:
- Shares the single SPI display bus (mosi/dc/cs) between NUM_REQ drawing clients, e.g. init sequencer, picture drawer and fill/text drawer.
- Each client raises a request and receives a one-cycle start pulse when granted.
- The granted client owns the bus until it pulses done. A watchdog reclaims the bus if done never arrives.
- Requester 0 is the panel-init client; it must finish once before any other client is served.

Parameters:
NUM_REQ, 3, number of requesting clients (2..8)
TIMEOUT, 16_000_000, max cycles a grant may last before forced release (≥2)
GAP_CYCLES, 4, cycles bus is held idle (cs high) between consecutive grants (≥1)
INIT_LOCK, 1, 1 = only requester 0 eligible until its first completed grant

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_req  input  NUM_REQ  level request per client; held until start pulse seen
i_done  input  NUM_REQ  one-cycle completion pulse per client
i_mosi  input  NUM_REQ  per-client serial data
i_dc  input  NUM_REQ  per-client data/command select
i_cs  input  NUM_REQ  per-client chip select (active-low)
o_start  output  NUM_REQ  one-hot, one-cycle start pulse to granted client
o_abort  output  NUM_REQ  one-hot, one-cycle pulse to client whose grant timed out
o_gnt  output  NUM_REQ  one-hot current owner, 0 when bus unowned
o_mosi  output  1  panel MOSI
o_dc  output  1  panel D/C
o_cs  output  1  panel CS (active-low)
o_busy  output  1  high in START/BUSY/GAP
o_timeout  output  1  one-cycle pulse when watchdog fires
o_init_done  output  1  high once requester 0 has completed a grant

Behaviour:
- Reset (async, i_rst high): state IDLE, grant index 0, last-served index NUM_REQ-1, timer 0, gap counter 0, init_done 0.
  - Outputs: o_start=0, o_abort=0, o_gnt=0, o_mosi=0, o_dc=0, o_cs=1, o_busy=0, o_timeout=0, o_init_done=0.
- Eligible set:
  - INIT_LOCK=1 and init_done=0: eligible = i_req[0] only.
  - Otherwise: eligible = i_req.
- IDLE:
  - Bus outputs idle (cs=1, mosi=0, dc=0); o_gnt=0.
  - If eligible ≠ 0, pick the winner round-robin, searching from last-served+1 upward with wrap at NUM_REQ.
  - Latch the winner index and go to START next cycle.
- START: exactly one cycle.
  - o_start[g]=1, o_gnt=onehot(g).
  - Bus muxed from client g.
  - Timer cleared; go to BUSY.
- BUSY: bus muxed from g; timer increments each cycle.
  - i_done[g]=1: last-served←g; if g==0, init_done←1; gap counter←0; go to GAP.
  - Else if timer==TIMEOUT-1: o_timeout=1 and o_abort[g]=1 for one cycle; last-served←g; go to GAP. init_done is not set.
  - Done and timeout in the same cycle: done wins, no timeout pulse.
  - i_done from non-granted clients is ignored in every state.
- GAP:
  - Bus idle, o_gnt=0, o_busy=1.
  - Stays for exactly GAP_CYCLES cycles, then goes to IDLE.
- Latency: request first seen in IDLE at cycle t → o_start at t+1. Minimum re-grant spacing after done is GAP_CYCLES+2 cycles (done → GAP ×GAP_CYCLES → IDLE → START).
- Bus mux:
  - Combinational from the latched index; adds no register stage, so client SPI timing is preserved.
  - The select changes only in IDLE, where cs is forced high.
- Timer width: clog2(TIMEOUT+1) bits; it never wraps because the timeout check precedes any wrap.
- Requests dropped before the grant are simply not considered. Requests dropped during BUSY have no effect; only done or timeout ends a grant.
- o_busy=0 only in IDLE.

Test Plan:
- Params NUM_REQ=3, TIMEOUT=100, GAP_CYCLES=4. After reset, i_req=3'b110 for 50 cycles → no o_start, o_cs=1, o_init_done=0.
- Raise i_req[0] at cycle t → o_start=3'b001 at t+1. Drive i_cs[0]=0, i_mosi[0] toggling → o_cs/o_mosi follow same cycle. Pulse i_done[0] → o_init_done=1; o_cs=1 for 5 cycles (GAP+IDLE); next grant o_start=3'b010 6 cycles after done.
- All three requesting continuously after init → grants rotate 1,2,0,1,2 with each client pulsing done after 10 cycles.
- Client 1 granted, never pulses done → o_timeout and o_abort=3'b010 exactly 100 cycles after START; o_gnt=0 next cycle; o_init_done unchanged.
- Pulse i_done[2] while client 1 owns the bus → ignored, state stays BUSY. i_done[1] on the same cycle as timer==99 → no o_timeout, normal GAP.
- Assert i_rst mid-BUSY with i_cs[1]=0 → o_cs=1, o_gnt=0, o_init_done=0 immediately (async); after release only requester 0 is grantable.
